// File: rtl/half_adder_lanes_pkg.sv
// Shared types for the multi-lane half adder: the per-lane {sum, carry} result.
package half_adder_lanes_pkg;

    typedef struct packed {
        logic o;
        logic c;
    } lane_res_t;

    localparam lane_res_t LANE_RES_ZERO = '{o: 1'b0, c: 1'b0};

    function automatic lane_res_t half_add(input logic a, input logic b);
        lane_res_t r;
        r.o = a ^ b;
        r.c = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_lanes_bit.sv
// One combinational half-adder lane: o = a ^ b, c = a & b.
module half_adder_bit
    import half_adder_lanes_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic o,
    output logic c
);

    lane_res_t res;

    always_comb begin
        res = half_add(a, b);
        o   = res.o;
        c   = res.c;
    end

endmodule

// File: rtl/half_adder_lanes.sv
// Registered multi-lane half adder with a skid buffer, so in_ready is a flop
// and carries no combinational path back from out_ready.
module half_adder_lanes
    import half_adder_lanes_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;

    lane_res_t [WIDTH-1:0] res;
    lane_res_t [WIDTH-1:0] main_q;
    lane_res_t [WIDTH-1:0] skid_q;
    logic                  main_vld;
    logic                  skid_vld;

    logic in_fire;
    logic main_open;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            half_adder_bit u_bit (
                .a (a[i]),
                .b (b[i]),
                .o (sum[i]),
                .c (carry[i])
            );
        end
    endgenerate

    always_comb begin
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res[i].o = sum[i];
            res[i].c = carry[i];
        end
    end

    assign in_ready  = ~skid_vld;
    assign in_fire   = in_valid & in_ready;
    assign main_open = ~main_vld | out_ready;

    // The skid always drains into main first so ordering is preserved; while
    // skid is full in_ready is low, so no new input competes with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (main_open) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_q   <= '0;
                skid_vld <= 1'b0;
            end else if (in_fire) begin
                main_q   <= res;
                main_vld <= 1'b1;
            end else begin
                main_q   <= '0;
                main_vld <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q   <= res;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid = main_vld;

    always_comb begin
        o = '0;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o[i] = main_q[i].o;
            c[i] = main_q[i].c;
        end
    end

endmodule

// File: tb/tb_half_adder_lanes.sv
// Scoreboard bench for half_adder_lanes (8 lanes): directed vectors, backpressure,
// mid-stream reset and a random stall run.
module tb_half_adder_lanes;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o;
    logic [W-1:0] c;

    half_adder_lanes #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .c         (c)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int cycle  = 0;
    bit auto_push = 1'b0;
    logic [2*W-1:0] exp_q[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cycle);
        end
    endtask

    // Monitor: compare presented output with queue front, pop on handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output o=%0h c=%0h with empty queue", o, c);
                end else begin
                    check("out_o", 32'(o), 32'(exp_q[0][2*W-1:W]));
                    check("out_c", 32'(c), 32'(exp_q[0][W-1:0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end else begin
                check("idle_zero_oc", 32'({o, c}), 32'd0);
            end
            if (auto_push && in_valid && in_ready)
                exp_q.push_back({a ^ b, a & b});
        end
    end

    // Present a pair and wait (bounded) for acceptance; push the hand result.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eo, input logic [W-1:0] ec);
        bit done = 1'b0;
        in_valid = 1'b1; a = av; b = bv;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({eo, ec});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout a=%0h b=%0h not accepted", av, bv);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; a = '0; b = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin @(posedge clk); #1; end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int t0, p0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_oc", 32'({o, c}), 32'd0);
        rst_n = 1'b1;

        // Truth table on lane 0, back to back.
        send(8'h00, 8'h00, 8'h00, 8'h00);
        send(8'h00, 8'h01, 8'h01, 8'h00);
        check("tt_valid_cont", 32'(out_valid), 32'd1);
        send(8'h01, 8'h00, 8'h01, 8'h00);
        check("tt_valid_cont", 32'(out_valid), 32'd1);
        send(8'h01, 8'h01, 8'h00, 8'h01);
        check("tt_valid_cont", 32'(out_valid), 32'd1);
        idle(2);

        // Multi-lane, no inter-lane carry.
        send(8'hF0, 8'hCC, 8'h3C, 8'hC0);
        check("ml_latency_o", 32'(o), 32'h3C);
        send(8'hFF, 8'h01, 8'hFE, 8'h01);
        check("ml_latency_c", 32'(c), 32'h01);
        send(8'hAA, 8'h55, 8'hFF, 8'h00);
        idle(2);

        // Backpressure: main holds first, skid takes second.
        out_ready = 1'b0;
        send(8'h01, 8'h01, 8'h00, 8'h01);
        send(8'h00, 8'h01, 8'h01, 8'h00);
        idle(1);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_oc", 32'({o, c}), 32'({8'h00, 8'h01}));
        idle(2);
        check("bp_still_held", 32'({o, c}), 32'({8'h00, 8'h01}));
        out_ready = 1'b1;
        idle(2);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Full throughput: 16 pairs in 16 cycles.
        t0 = cycle; p0 = pops;
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            send(ra, rb, ra ^ rb, ra & rb);
        end
        check("tp_cycles", 32'(cycle - t0), 32'd16);
        idle(2);
        check("tp_results", 32'(pops - p0), 32'd16);

        // Reset with main and skid full; input presented during reset is dropped.
        out_ready = 1'b0;
        send(8'h0F, 8'h33, 8'h3C, 8'h03);
        send(8'h11, 8'h22, 8'h33, 8'h00);
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
        exp_q.delete();
        @(posedge clk); #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_oc", 32'({o, c}), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        idle(4);
        check("mrst_no_stale", 32'(out_valid), 32'd0);

        // Random stall run.
        auto_push = 1'b1;
        p0 = pops;
        for (int i = 0; i < 1000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        auto_push = 1'b0;
        checks++;
        if (pops - p0 < 50) begin
            errors++;
            $display("FAIL rand_activity actual=%0d required>=50", pops - p0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
